core_dispatch_queue: RTL and testbench

CORE_DISPATCH_QUEUE -- requirements
Module: core_dispatch_queue

---
 rtl/core_dispatch_queue_pkg.sv | 28 ++
 rtl/core_dispatch_queue_perf.sv | 46 ++++
 rtl/core_dispatch_queue.sv | 99 +++++++++
 tb/tb_core_dispatch_queue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_dispatch_queue_pkg.sv
// Shared decode-side types for the dispatch queue: the instruction record,
// the bubble constant and the pointer/occupancy width helpers.
package core_dispatch_queue_pkg;

  typedef struct packed {
    logic       execute;
    logic [2:0] fu;
    logic [4:0] rd;
  } insn_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op;
    insn_ctrl    ctrl;
  } insn_decode;

  // All-zero with execute clear, so the hazard stage always treats it as issuable.
  localparam insn_decode INSN_BUBBLE = '0;

  function automatic int dq_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int dq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/core_dispatch_queue_perf.sv
// Issue-width histogram for the dispatch queue: cycles with 0, 1 or 2 entries
// popped. Only instantiated when CORE_DISPATCH_QUEUE_PERF_EN is defined.
module core_dispatch_queue_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [1:0]  pop_n,
  output logic [31:0] perf_issue0,
  output logic [31:0] perf_issue1,
  output logic [31:0] perf_issue2
);

  logic [31:0] issue0_q, issue0_d;
  logic [31:0] issue1_q, issue1_d;
  logic [31:0] issue2_q, issue2_d;

  always_comb begin
    issue0_d = issue0_q;
    issue1_d = issue1_q;
    issue2_d = issue2_q;
    if (!flush) begin
      case (pop_n)
        2'd0:    issue0_d = issue0_q + 32'd1;
        2'd1:    issue1_d = issue1_q + 32'd1;
        default: issue2_d = issue2_q + 32'd1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue0_q <= '0;
      issue1_q <= '0;
      issue2_q <= '0;
    end else begin
      issue0_q <= issue0_d;
      issue1_q <= issue1_d;
      issue2_q <= issue2_d;
    end
  end

  assign perf_issue0 = issue0_q;
  assign perf_issue1 = issue1_q;
  assign perf_issue2 = issue2_q;

endmodule

// File: rtl/core_dispatch_queue.sv
// Two-wide in-order dispatch queue between decode and the hazard stage.
// Optional macro CORE_DISPATCH_QUEUE_PERF_EN adds perf_issue0/1/2 counters.
module core_dispatch_queue
  import core_dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  insn_decode                   in_a,
  input  insn_decode                   in_b,
  input  logic                         in_valid_a,
  input  logic                         in_valid_b,
  output logic                         in_ready,
  input  logic                         flush,
  input  logic                         dispatch_a,
  input  logic                         dispatch_b,
  output insn_decode                   cur_a,
  output insn_decode                   cur_b,
  output logic [dq_cnt_w(DEPTH)-1:0]   count,
  output logic                         empty
`ifdef CORE_DISPATCH_QUEUE_PERF_EN
  ,
  output logic [31:0]                  perf_issue0,
  output logic [31:0]                  perf_issue1,
  output logic [31:0]                  perf_issue2
`endif
);

  localparam int PTR_W = dq_ptr_w(DEPTH);
  localparam int CNT_W = dq_cnt_w(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  insn_decode       mem_q [DEPTH];

  logic [1:0]       push_n, pop_req, pop_n;
  logic             wr0_en, wr1_en;
  logic [PTR_W-1:0] wr0_idx, wr1_idx;
  insn_decode       wr0_data;

  // Ready looks only at registered occupancy so decode never waits on this cycle's pops.
  assign in_ready = (count_q <= CNT_W'(DEPTH - 2));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign cur_a    = (count_q >= CNT_W'(1)) ? mem_q[head_q] : INSN_BUBBLE;
  assign cur_b    = (count_q >= CNT_W'(2)) ? mem_q[head_q + PTR_W'(1)] : INSN_BUBBLE;

  always_comb begin
    pop_req  = dispatch_a ? (dispatch_b ? 2'd2 : 2'd1) : 2'd0;
    pop_n    = (CNT_W'(pop_req) > count_q) ? count_q[1:0] : pop_req;
    push_n   = in_ready ? (2'(in_valid_a) + 2'(in_valid_b)) : 2'd0;
    // A lone younger slot is compacted into the older slot's position.
    wr0_en   = in_ready && (in_valid_a || in_valid_b) && !flush;
    wr1_en   = in_ready && in_valid_a && in_valid_b && !flush;
    wr0_idx  = tail_q;
    wr1_idx  = tail_q + PTR_W'(1);
    wr0_data = in_valid_a ? in_a : in_b;
    head_d   = head_q + PTR_W'(pop_n);
    tail_d   = tail_q + PTR_W'(push_n);
    count_d  = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr0_en) mem_q[wr0_idx] <= wr0_data;
    if (!rst && wr1_en) mem_q[wr1_idx] <= in_b;
  end

`ifdef CORE_DISPATCH_QUEUE_PERF_EN
  core_dispatch_queue_perf u_perf (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .pop_n       (pop_n),
    .perf_issue0 (perf_issue0),
    .perf_issue1 (perf_issue1),
    .perf_issue2 (perf_issue2)
  );
`endif

endmodule

// File: tb/tb_core_dispatch_queue.sv
// Directed bench for core_dispatch_queue with a queue-based reference model
// compared every cycle, plus literal checks on hand-worked scenarios.
module tb_core_dispatch_queue;
  import core_dispatch_queue_pkg::*;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rst;
  insn_decode in_a, in_b;
  logic       in_valid_a, in_valid_b;
  logic       in_ready;
  logic       flush;
  logic       dispatch_a, dispatch_b;
  insn_decode cur_a, cur_b;
  logic [3:0] count;
  logic       empty;
`ifdef CORE_DISPATCH_QUEUE_PERF_EN
  logic [31:0] perf_issue0, perf_issue1, perf_issue2;
`endif

  int tests = 0;
  int fails = 0;
  bit started = 0;

  core_dispatch_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_valid_a (in_valid_a),
    .in_valid_b (in_valid_b),
    .in_ready   (in_ready),
    .flush      (flush),
    .dispatch_a (dispatch_a),
    .dispatch_b (dispatch_b),
    .cur_a      (cur_a),
    .cur_b      (cur_b),
    .count      (count),
    .empty      (empty)
`ifdef CORE_DISPATCH_QUEUE_PERF_EN
    ,
    .perf_issue0 (perf_issue0),
    .perf_issue1 (perf_issue1),
    .perf_issue2 (perf_issue2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic insn_decode mk(input int n);
    insn_decode r;
    r.pc           = 32'h1000 + 32'(n) * 32'd4;
    r.op           = 32'hA000_0000 | 32'(n);
    r.ctrl.execute = 1'b1;
    r.ctrl.fu      = 3'(n);
    r.ctrl.rd      = 5'(n);
    return r;
  endfunction

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_insn(input string name, input insn_decode act, input insn_decode exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of instructions in program order.
  insn_decode mq[$];
  int pm0 = 0, pm1 = 0, pm2 = 0;

  always @(posedge clk) begin : model
    int  np;
    bit  rdy;
    rdy = (mq.size() <= DEPTH - 2);
    np  = dispatch_a ? (dispatch_b ? 2 : 1) : 0;
    if (np > mq.size()) np = mq.size();
    if (rst) begin
      mq.delete();
      pm0 = 0; pm1 = 0; pm2 = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (np == 0) pm0++;
      else if (np == 1) pm1++;
      else pm2++;
      for (int i = 0; i < np; i++) void'(mq.pop_front());
      if (rdy) begin
        if (in_valid_a) mq.push_back(in_a);
        if (in_valid_b) mq.push_back(in_b);
      end
    end
  end

  always @(negedge clk) begin : compare
    if (started) begin
      chk_int("m_count", int'(count), mq.size());
      chk_int("m_empty", int'(empty), int'(mq.size() == 0));
      chk_int("m_in_ready", int'(in_ready), int'(mq.size() <= DEPTH - 2));
      chk_insn("m_cur_a", cur_a, (mq.size() >= 1) ? mq[0] : insn_decode'('0));
      chk_insn("m_cur_b", cur_b, (mq.size() >= 2) ? mq[1] : insn_decode'('0));
`ifdef CORE_DISPATCH_QUEUE_PERF_EN
      chk_int("m_perf0", int'(perf_issue0), pm0);
      chk_int("m_perf1", int'(perf_issue1), pm1);
      chk_int("m_perf2", int'(perf_issue2), pm2);
`endif
    end
  end

  task automatic drv(input bit va, input int na, input bit vb, input int nb,
                     input bit da, input bit db, input bit fl);
    in_valid_a = va;
    in_a       = mk(na);
    in_valid_b = vb;
    in_b       = mk(nb);
    dispatch_a = da;
    dispatch_b = db;
    flush      = fl;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    started = 1'b1;
    rst = 1'b0;
    chk_int("rst_count", int'(count), 0);
    chk_int("rst_empty", int'(empty), 1);
    chk_int("rst_ready", int'(in_ready), 1);
    chk_insn("rst_cur_a", cur_a, '0);
    chk_insn("rst_cur_b", cur_b, '0);

    // Pair push lands on cur_a/cur_b one cycle later.
    drv(1, 0, 1, 1, 0, 0, 0); tick();
    chk_insn("push2_cur_a", cur_a, mk(0));
    chk_insn("push2_cur_b", cur_b, mk(1));
    chk_int("push2_count", int'(count), 2);

    drv(1, 2, 1, 3, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 1, 0, 0); tick();
    chk_insn("pop1_cur_a", cur_a, mk(1));
    chk_insn("pop1_cur_b", cur_b, mk(2));
    chk_int("pop1_count", int'(count), 3);

    // Younger-only push into an empty queue, then over-grant.
    drv(0, 0, 0, 0, 0, 0, 1); tick();
    chk_int("flush_count", int'(count), 0);
    drv(0, 0, 1, 5, 0, 0, 0); tick();
    chk_insn("bonly_cur_a", cur_a, mk(5));
    chk_insn("bonly_cur_b", cur_b, '0);
    chk_int("bonly_count", int'(count), 1);
    drv(0, 0, 0, 0, 1, 1, 0); tick();
    chk_int("clamp_count", int'(count), 0);
    chk_int("clamp_empty", int'(empty), 1);

    // dispatch_b alone pops nothing.
    drv(1, 6, 1, 7, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 1, 0); tick();
    chk_int("donly_b_count", int'(count), 2);
    chk_insn("donly_b_cur_a", cur_a, mk(6));

    // Fill to DEPTH-1 and confirm backpressure.
    drv(1, 8, 1, 9, 0, 0, 0); tick();
    drv(1, 10, 1, 11, 0, 0, 0); tick();
    drv(1, 12, 0, 0, 0, 0, 0); tick();
    chk_int("full7_count", int'(count), 7);
    chk_int("full7_ready", int'(in_ready), 0);
    drv(1, 20, 1, 21, 0, 0, 0); tick();
    chk_int("ignored_count", int'(count), 7);
    drv(1, 22, 1, 23, 1, 1, 0); tick();
    chk_int("drain_count", int'(count), 5);
    chk_int("drain_ready", int'(in_ready), 1);
    chk_insn("drain_cur_a", cur_a, mk(8));
    chk_insn("drain_cur_b", cur_b, mk(9));

    // Flush beats simultaneous push and pop.
    drv(1, 13, 0, 0, 0, 0, 0); tick();
    chk_int("six_count", int'(count), 6);
    drv(1, 30, 1, 31, 1, 1, 1); tick();
    chk_int("flushprio_count", int'(count), 0);
    chk_int("flushprio_empty", int'(empty), 1);
    chk_insn("flushprio_cur_a", cur_a, '0);

    // Reset mid-operation overrides push, pop and flush.
    drv(1, 40, 1, 41, 0, 0, 0); tick();
    rst = 1'b1;
    drv(1, 42, 1, 43, 1, 0, 1); tick();
    rst = 1'b0;
    chk_int("midrst_count", int'(count), 0);
    chk_insn("midrst_cur_a", cur_a, '0);

    // Two in, two out for 20 cycles across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      drv(1, 100 + 2 * i, 1, 101 + 2 * i, 1, 1, 0);
      tick();
    end
    chk_int("stream_count", int'(count), 2);
    chk_insn("stream_cur_a", cur_a, mk(138));
    chk_insn("stream_cur_b", cur_b, mk(139));
`ifdef CORE_DISPATCH_QUEUE_PERF_EN
    chk_int("perf_issue2", int'(perf_issue2), 19);
    chk_int("perf_issue0", int'(perf_issue0), 1);
    chk_int("perf_issue1", int'(perf_issue1), 0);
`endif
    idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
